// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-to-RAM memory interface stage.
package cpu_mem_pkg;

  // Access controller states.
  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

  // Pattern loaded into MDR when a read is abandoned, so stale data is obvious.
  localparam logic [31:0] MEM_POISON = 32'hDEADBEEF;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter guarding an outstanding RAM access; flags when TIMEOUT is reached.
module mem_timeout_ctr
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins, otherwise step while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR holding stage that turns control-unit strobes into a RAM req/ack
// transaction, stalls the control unit via busy, and aborts hung accesses.
module mem_interface
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              MD_read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              tc_s;

  logic rd_start_s, illegal_s, busy_cmd_s;
  assign rd_start_s = MDRin & MD_read;
  assign illegal_s  = Write & rd_start_s;
  assign busy_cmd_s = MARin | MDRin | Write;

  // Counter is held at zero while idle so every access starts from a fresh count.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == MEM_IDLE),
    .en    (~mem_ack & ~tc_s),
    .tc    (tc_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start accesses from idle, finish on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: begin
        if (illegal_s) begin
          state_d = MEM_IDLE;
        end else if (rd_start_s) begin
          state_d = MEM_RD_WAIT;
        end else if (Write) begin
          state_d = MEM_WR_WAIT;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_RD_WAIT, MEM_WR_WAIT: begin
        if (mem_ack || tc_s) begin
          state_d = MEM_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Datapath and flag updates; MAR loads before any access it launches.
  always_comb begin
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    busy_d    = (state_d != MEM_IDLE);
    mem_req_d = (state_d != MEM_IDLE);
    mem_we_d  = (state_d == MEM_WR_WAIT);
    case (state_q)
      MEM_IDLE: begin
        if (MARin) begin
          mar_d = bus_in[ADDR_W-1:0];
        end else begin
          mar_d = mar_q;
        end
        if (MDRin && !MD_read) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        if (illegal_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      MEM_RD_WAIT, MEM_WR_WAIT: begin
        if (mem_ack) begin
          done_d = 1'b1;
          if (state_q == MEM_RD_WAIT) begin
            mdr_d = mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          err_d = err_q | busy_cmd_s;
        end else if (tc_s) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          if (state_q == MEM_RD_WAIT) begin
            mdr_d = DATA_W'(MEM_POISON);
          end else begin
            mdr_d = mdr_q;
          end
        end else begin
          err_d = err_q | busy_cmd_s;
        end
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
  end

  // Registered datapath and outputs; reset drops mem_req immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mar_q     <= '0;
      mdr_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_interface;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TMO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          MARin = 1'b0, MDRin = 1'b0, MD_read = 1'b0, Write = 1'b0;
  logic [DW-1:0] mdr_q;
  logic [AW-1:0] mar_q;
  logic          busy, done, err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, timed by its start cycle.
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;
  logic          m_err, m_done, m_pend, m_is_wr;
  int            m_cyc, m_start;

  mem_interface #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in),
    .MARin(MARin), .MDRin(MDRin), .MD_read(MD_read), .Write(Write),
    .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mar = '0; m_mdr = '0; m_err = 1'b0; m_done = 1'b0;
    m_pend = 1'b0; m_is_wr = 1'b0; m_cyc = 0; m_start = 0;
  endtask

  task automatic model_step(input logic ma, input logic md, input logic rd,
                            input logic wr, input logic [DW-1:0] bus,
                            input logic ack, input logic [DW-1:0] rdata);
    m_cyc++;
    m_done = 1'b0;
    if (!m_pend) begin
      if (ma) m_mar = bus[AW-1:0];
      if (wr && md && rd) begin
        m_err = 1'b1;
      end else begin
        if (md && !rd) m_mdr = bus;
        if (md && rd) begin
          m_pend = 1'b1; m_is_wr = 1'b0; m_start = m_cyc;
        end else if (wr) begin
          m_pend = 1'b1; m_is_wr = 1'b1; m_start = m_cyc;
        end
      end
    end else begin
      if (ack) begin
        if (ma || md || wr) m_err = 1'b1;
        if (!m_is_wr) m_mdr = rdata;
        m_done = 1'b1; m_pend = 1'b0;
      end else if (m_cyc == m_start + TMO + 1) begin
        if (!m_is_wr) m_mdr = 32'hDEADBEEF;
        m_err = 1'b1; m_done = 1'b1; m_pend = 1'b0;
      end else if (ma || md || wr) begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy", busy, m_pend);
    chk("mem_req", mem_req, m_pend);
    chk("mem_we", mem_we, m_pend && m_is_wr);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("mar", mar_q, m_mar);
    chk("mdr", mdr_q, m_mdr);
    if (m_pend) begin
      chk("mem_addr", mem_addr, m_mar);
      chk("mem_wdata", mem_wdata, m_mdr);
    end
  endtask

  task automatic cycle(input logic ma, input logic md, input logic rd, input logic wr,
                       input logic [DW-1:0] bus, input logic ack, input logic [DW-1:0] rdata);
    @(negedge clock);
    MARin = ma; MDRin = md; MD_read = rd; Write = wr;
    bus_in = bus; mem_ack = ack; mem_rdata = rdata;
    @(posedge clock);
    model_step(ma, md, rd, wr, bus, ack, rdata);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic ack, input logic [DW-1:0] rdata);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ack, rdata);
  endtask

  // Asynchronous reset mid-cycle, with a stray ack held across it.
  task automatic apply_reset();
    @(negedge clock);
    MARin = 1'b0; MDRin = 1'b0; MD_read = 1'b0; Write = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (2) begin
      @(posedge clock);
      #1;
      compare_all();
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  int busy_cnt, done_cnt, done_at;

  initial begin
    model_reset();
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b1;

    // Read from 0x1F4, ack after three waiting cycles.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h000001F4, 1'b0, 32'h0);
    busy_cnt = 0; done_cnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rd_addr", mem_addr, 32'h1F4);
    chk("rd_we", mem_we, 32'h0);
    busy_cnt += int'(busy); done_cnt += int'(done);
    for (int k = 0; k < 5; k++) begin
      idle(k == 3, 32'h12345678);
      busy_cnt += int'(busy); done_cnt += int'(done);
    end
    chk("rd_busy_edges", busy_cnt, 32'd4);
    chk("rd_done_pulses", done_cnt, 32'd1);
    chk("rd_mdr", mdr_q, 32'h12345678);

    // Write 0xCAFEF00D to 0x010, ack on the next edge.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000010, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("wr_we", mem_we, 32'h1);
    chk("wr_wdata", mem_wdata, 32'hCAFEF00D);
    chk("wr_addr", mem_addr, 32'h010);
    idle(1'b1, 32'h0);
    chk("wr_err", err, 32'h0);
    idle(1'b0, 32'h0);

    // Read that never gets an ack.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      idle(1'b0, 32'h0);
      if (done && done_at < 0) done_at = k;
    end
    chk("tmo_edge", done_at, TMO + 1);
    chk("tmo_mdr", mdr_q, 32'hDEADBEEF);
    chk("tmo_err", err, 32'h1);
    chk("tmo_idle", busy, 32'h0);

    // Commands while a read is pending are refused.
    apply_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000033, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h000000AA, 1'b0, 32'h0);
    chk("busy_mar", mar_q, 32'h033);
    chk("busy_we", mem_we, 32'h0);
    chk("busy_err", err, 32'h1);
    idle(1'b1, 32'hA5A5F00F);
    chk("busy_rd_mdr", mdr_q, 32'hA5A5F00F);
    idle(1'b0, 32'h0);

    // Illegal write+read combination in idle.
    apply_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h13572468, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0);
    chk("ill_req", mem_req, 32'h0);
    chk("ill_err", err, 32'h1);
    chk("ill_mdr", mdr_q, 32'h13572468);

    // Reset during a write; ack arrives around and after reset.
    apply_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000155, 1'b0, 32'h0);
    idle(1'b0, 32'h0);
    chk("rstw_req_before", mem_req, 32'h1);
    apply_reset();
    chk("rstw_req", mem_req, 32'h0);
    idle(1'b1, 32'h77777777);
    chk("rstw_mdr", mdr_q, 32'h0);

    // Random traffic with periodic resets.
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 149) begin
        apply_reset();
      end else if (!m_pend) begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
              $urandom, $urandom_range(0, 5) == 0, $urandom);
      end else begin
        cycle($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 1) == 0, $urandom_range(0, 24) == 0,
              $urandom, $urandom_range(0, 5) == 0, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
